// File: rtl/rot_xfer_sched.sv
// Transfer scheduler for the rotation engine: splits an HxW word image into per-row DMA bursts.
// Optional busy-cycle counter is built when ROT_XS_PERF_EN is defined.
module rot_xfer_sched #(
    parameter int MAX_BURST = 16,
    parameter int DIM_W     = 16
) (
    input  logic             I_XS_HCLK,
    input  logic             I_XS_HRESET_N,
    input  logic             I_XS_RESET,
    input  logic             I_XS_START,
    input  logic [31:0]      I_XS_SRC_IMG,
    input  logic [31:0]      I_XS_DST_IMG,
    input  logic [DIM_W-1:0] I_XS_HEIGHT,
    input  logic [DIM_W-1:0] I_XS_WIDTH,
    input  logic             I_XS_INTR_MASK,
    input  logic             I_XS_INTR_CLEAR,
    output logic             O_XS_REQ,
    input  logic             I_XS_ACK,
    input  logic             I_XS_XFER_DONE,
    output logic [31:0]      O_XS_ADDR,
    output logic [4:0]       O_XS_COUNT,
    output logic             O_XS_WRITE,
    output logic             O_XS_PROC,
    input  logic             I_XS_PROC_DONE,
    output logic             O_XS_BUSY,
    output logic             O_XS_ERR,
    output logic             O_XS_INTR_DONE,
    output logic [31:0]      O_XS_CYCLES
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_PROC, S_PROC_WAIT,
        S_WR_REQ, S_WR_WAIT, S_NEXT, S_DONE
    } state_e;

    state_e           state_q;
    logic [31:0]      src_ptr_q, dst_ptr_q, addr_q;
    logic [DIM_W-1:0] row_q, col_q, h_q, w_q;
    logic [4:0]       count_q;
    logic             req_q, write_q, proc_q, pend_q, err_q;

    logic [31:0]      src_ptr_d, dst_ptr_d, step;
    logic [DIM_W-1:0] col_sum, row_inc, col_d, row_d;
    logic             row_wrap, last_chunk;

    function automatic logic [4:0] burst_len(input logic [DIM_W-1:0] remaining);
        if (remaining >= DIM_W'(MAX_BURST))
            return 5'(MAX_BURST);
        else
            return remaining[4:0];
    endfunction

    // Pointer/row/column advance applied when leaving NEXT.
    assign step       = {25'd0, count_q, 2'b00};
    assign src_ptr_d  = src_ptr_q + step;
    assign dst_ptr_d  = dst_ptr_q + step;
    assign col_sum    = col_q + DIM_W'(count_q);
    assign row_inc    = row_q + DIM_W'(1);
    assign row_wrap   = (col_sum == w_q);
    assign col_d      = row_wrap ? '0 : col_sum;
    assign row_d      = row_wrap ? row_inc : row_q;
    assign last_chunk = row_wrap && (row_inc == h_q);

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge I_XS_HCLK or negedge I_XS_HRESET_N) begin
        if (!I_XS_HRESET_N) begin
            state_q   <= S_IDLE;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            addr_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            h_q       <= '0;
            w_q       <= '0;
            count_q   <= '0;
            req_q     <= 1'b0;
            write_q   <= 1'b0;
            proc_q    <= 1'b0;
            pend_q    <= 1'b0;
            err_q     <= 1'b0;
        end else if (I_XS_RESET) begin
            state_q   <= S_IDLE;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            addr_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            h_q       <= '0;
            w_q       <= '0;
            count_q   <= '0;
            req_q     <= 1'b0;
            write_q   <= 1'b0;
            proc_q    <= 1'b0;
            pend_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            proc_q <= 1'b0;
            if (I_XS_INTR_CLEAR)
                pend_q <= 1'b0;
            case (state_q)
                S_IDLE: if (I_XS_START) begin
                    h_q <= I_XS_HEIGHT;
                    w_q <= I_XS_WIDTH;
                    if (I_XS_HEIGHT == '0 || I_XS_WIDTH == '0) begin
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        err_q     <= 1'b0;
                        src_ptr_q <= I_XS_SRC_IMG;
                        dst_ptr_q <= I_XS_DST_IMG;
                        row_q     <= '0;
                        col_q     <= '0;
                        addr_q    <= I_XS_SRC_IMG;
                        write_q   <= 1'b0;
                        count_q   <= burst_len(I_XS_WIDTH);
                        req_q     <= 1'b1;
                        state_q   <= S_RD_REQ;
                    end
                end
                S_RD_REQ: if (I_XS_ACK) begin
                    req_q   <= 1'b0;
                    state_q <= S_RD_WAIT;
                end
                S_RD_WAIT: if (I_XS_XFER_DONE) begin
                    proc_q  <= 1'b1;
                    state_q <= S_PROC;
                end
                S_PROC: state_q <= S_PROC_WAIT;
                S_PROC_WAIT: if (I_XS_PROC_DONE) begin
                    addr_q  <= dst_ptr_q;
                    write_q <= 1'b1;
                    req_q   <= 1'b1;
                    state_q <= S_WR_REQ;
                end
                S_WR_REQ: if (I_XS_ACK) begin
                    req_q   <= 1'b0;
                    state_q <= S_WR_WAIT;
                end
                S_WR_WAIT: if (I_XS_XFER_DONE) state_q <= S_NEXT;
                S_NEXT: begin
                    src_ptr_q <= src_ptr_d;
                    dst_ptr_q <= dst_ptr_d;
                    col_q     <= col_d;
                    row_q     <= row_d;
                    if (last_chunk) begin
                        state_q <= S_DONE;
                    end else begin
                        addr_q  <= src_ptr_d;
                        write_q <= 1'b0;
                        count_q <= burst_len(w_q - col_d);
                        req_q   <= 1'b1;
                        state_q <= S_RD_REQ;
                    end
                end
                S_DONE: begin
                    pend_q  <= 1'b1;   // overrides a coincident clear
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign O_XS_REQ       = req_q;
    assign O_XS_ADDR      = addr_q;
    assign O_XS_COUNT     = count_q;
    assign O_XS_WRITE     = write_q;
    assign O_XS_PROC      = proc_q;
    assign O_XS_ERR       = err_q;
    assign O_XS_BUSY      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign O_XS_INTR_DONE = pend_q & ~I_XS_INTR_MASK;

`ifdef ROT_XS_PERF_EN
    logic [31:0] cycles_q;

    always_ff @(posedge I_XS_HCLK or negedge I_XS_HRESET_N) begin
        if (!I_XS_HRESET_N)
            cycles_q <= '0;
        else if (I_XS_RESET || (state_q == S_IDLE && I_XS_START))
            cycles_q <= '0;
        else if (O_XS_BUSY && cycles_q != 32'hFFFF_FFFF)
            cycles_q <= cycles_q + 32'd1;
    end

    assign O_XS_CYCLES = cycles_q;
`else
    assign O_XS_CYCLES = '0;
`endif

endmodule

// File: tb/tb_rot_xfer_sched.sv
// Directed bench for rot_xfer_sched: a hand-driven DMA/core responder checks each command against
// hand-computed address/count/direction, plus reset, error, soft reset, interrupt and counter behaviour.
module tb_rot_xfer_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        soft_rst = 1'b0, start = 1'b0;
    logic [31:0] src = '0, dst = '0;
    logic [15:0] height = '0, width = '0;
    logic        mask = 1'b0, clr = 1'b0;
    logic        ack = 1'b0, xfer_done = 1'b0, proc_done = 1'b0;
    logic        req, wr, proc, busy, err, intr;
    logic [31:0] addr, cycles;
    logic [4:0]  count;

    int total = 0;
    int bad = 0;
    int proc_seen = 0;
    int busy_meas = 0;
    int p0;

    always #5 clk = ~clk;

    rot_xfer_sched dut (
        .I_XS_HCLK(clk), .I_XS_HRESET_N(rst_n), .I_XS_RESET(soft_rst), .I_XS_START(start),
        .I_XS_SRC_IMG(src), .I_XS_DST_IMG(dst), .I_XS_HEIGHT(height), .I_XS_WIDTH(width),
        .I_XS_INTR_MASK(mask), .I_XS_INTR_CLEAR(clr), .O_XS_REQ(req), .I_XS_ACK(ack),
        .I_XS_XFER_DONE(xfer_done), .O_XS_ADDR(addr), .O_XS_COUNT(count), .O_XS_WRITE(wr),
        .O_XS_PROC(proc), .I_XS_PROC_DONE(proc_done), .O_XS_BUSY(busy), .O_XS_ERR(err),
        .O_XS_INTR_DONE(intr), .O_XS_CYCLES(cycles)
    );

    always @(negedge clk) begin
        if (proc) proc_seen++;
        if (busy) busy_meas++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [15:0] h,
                        input logic [15:0] w);
        src = s; dst = d; height = h; width = w;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // One DMA command: wait for REQ, compare it, accept it, complete it, and serve the core for reads.
    task automatic serve(input string tag, input logic [31:0] a, input logic [4:0] n,
                         input logic w, input int dly);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (req) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check({tag, "_req"}, 32'(ok), 32'd1);
        if (!ok) return;
        check({tag, "_addr"}, addr, a);
        check({tag, "_cnt"}, 32'(count), 32'(n));
        check({tag, "_wr"}, 32'(wr), 32'(w));
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            check({tag, "_hold"}, {req, wr, 1'b0, count, addr[23:0]}, {1'b1, w, 1'b0, n, a[23:0]});
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check({tag, "_reqdrop"}, 32'(req), 32'd0);
        repeat (dly) @(negedge clk);
        xfer_done = 1'b1;
        @(negedge clk);
        xfer_done = 1'b0;
        if (!w) begin
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (proc) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            check({tag, "_proc"}, 32'(ok), 32'd1);
            @(negedge clk);
            check({tag, "_proc1"}, 32'(proc), 32'd0);
            proc_done = 1'b1;
            @(negedge clk);
            proc_done = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (!busy) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check({tag, "_idle"}, 32'(ok), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out", {req, wr, proc, busy, err, intr, count, 21'd0},
              {6'd0, 5'd0, 21'd0});
        check("rst_addr", addr, 32'h0);
        check("rst_cycles", cycles, 32'h0);

        // 4x2 image: four commands, one chunk per row
        p0 = proc_seen;
        kick(32'h1000, 32'h2000, 16'd2, 16'd4);
        check("t1_latency", 32'(req), 32'd1);
        serve("t1_r0", 32'h1000, 5'd4, 1'b0, 0);
        serve("t1_w0", 32'h2000, 5'd4, 1'b1, 0);
        serve("t1_r1", 32'h1010, 5'd4, 1'b0, 0);
        serve("t1_w1", 32'h2010, 5'd4, 1'b1, 0);
        wait_idle("t1");
        check("t1_intr", 32'(intr), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_err", 32'(err), 32'd0);
        check("t1_procs", 32'(proc_seen - p0), 32'd2);
        pulse_clear();
        check("t1_clear", 32'(intr), 32'd0);

        // 20-word row: full burst then a 4-word tail
        p0 = proc_seen;
        kick(32'h1000, 32'h2000, 16'd1, 16'd20);
        serve("t2_r0", 32'h1000, 5'd16, 1'b0, 0);
        serve("t2_w0", 32'h2000, 5'd16, 1'b1, 0);
        serve("t2_r1", 32'h1040, 5'd4, 1'b0, 0);
        serve("t2_w1", 32'h2040, 5'd4, 1'b1, 0);
        wait_idle("t2");
        check("t2_intr", 32'(intr), 32'd1);
        check("t2_procs", 32'(proc_seen - p0), 32'd2);
        pulse_clear();

        // zero width: error, no commands, interrupt two cycles after START
        kick(32'h1000, 32'h2000, 16'd5, 16'd0);
        check("t3_state", {req, busy, err, intr}, 4'b0010);
        @(negedge clk);
        check("t3_intr", 32'(intr), 32'd1);
        repeat (4) @(negedge clk);
        check("t3_noreq", {req, busy, err}, 3'b001);

        // start with pend set keeps pend, clears err; soft reset in RD_WAIT aborts and clears pend
        kick(32'h1000, 32'h2000, 16'd1, 16'd4);
        check("t4_err_clr", 32'(err), 32'd0);
        check("t4_pend_kept", 32'(intr), 32'd1);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        soft_rst = 1'b1;
        @(negedge clk);
        soft_rst = 1'b0;
        check("t4_abort", {req, busy, intr}, 3'b000);
        ack = 1'b1; xfer_done = 1'b1; proc_done = 1'b1;
        @(negedge clk);
        ack = 1'b0; xfer_done = 1'b0; proc_done = 1'b0;
        @(negedge clk);
        check("t4_stray", {req, busy, proc, intr}, 4'b0000);
        kick(32'h1000, 32'h2000, 16'd1, 16'd4);
        serve("t4_r0", 32'h1000, 5'd4, 1'b0, 0);
        serve("t4_w0", 32'h2000, 5'd4, 1'b1, 0);
        wait_idle("t4");
        check("t4_intr", 32'(intr), 32'd1);
        pulse_clear();

        // masked completion; START while busy is ignored
        mask = 1'b1;
        kick(32'h1000, 32'h2000, 16'd1, 16'd4);
        kick(32'h9000, 32'hA000, 16'd3, 16'd8);
        serve("t5_r0", 32'h1000, 5'd4, 1'b0, 0);
        serve("t5_w0", 32'h2000, 5'd4, 1'b1, 0);
        wait_idle("t5");
        repeat (3) @(negedge clk);
        check("t5_masked", {req, busy, intr}, 3'b000);
        mask = 1'b0;
        #1;
        check("t5_unmask", 32'(intr), 32'd1);
        @(negedge clk);
        pulse_clear();
        check("t5_clear", 32'(intr), 32'd0);

        // slow DMA: 3-cycle ACK and DONE delays, busy-cycle counter
        busy_meas = 0;
        kick(32'h1000, 32'h2000, 16'd1, 16'd4);
        serve("t6_r0", 32'h1000, 5'd4, 1'b0, 3);
        serve("t6_w0", 32'h2000, 5'd4, 1'b1, 3);
        wait_idle("t6");
        check("t6_intr", 32'(intr), 32'd1);
`ifdef ROT_XS_PERF_EN
        check("t6_cycles", cycles, 32'(busy_meas));
`else
        check("t6_cycles", cycles, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
